// File: rtl/minmax_stream.sv
// Streaming min/max tracker: reduces NI valid/ready samples to {result, index}.
// Optional early end-of-frame (s_last, m_count) under `MINMAX_STREAM_LAST_EN.
module minmax_stream #(
  parameter int W    = 12,
  parameter int NI   = 9,
  parameter int IDXW = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            us_sel,
  input  logic            min_max_sel,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
`ifdef MINMAX_STREAM_LAST_EN
  input  logic            s_last,
  output logic [IDXW:0]   m_count,
`endif
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_result,
  output logic [IDXW-1:0] m_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NI - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    best_q, best_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            us_q, us_d;
  logic            mm_q, mm_d;
  logic            alive_q;
  logic            beat;
  logic            lt, gt, better, end_beat;
`ifdef MINMAX_STREAM_LAST_EN
  logic [IDXW:0]   count_q, count_d;
`endif

  // alive_q keeps s_ready low while reset is asserted and releases it one cycle later
  assign s_ready  = alive_q && (state_q != OUT);
  assign m_valid  = (state_q == OUT);
  assign m_result = best_q;
  assign m_index  = idx_q;
  assign beat     = s_valid && s_ready;
`ifdef MINMAX_STREAM_LAST_EN
  assign m_count  = count_q;
`endif

  always_comb begin
    lt = 1'b0;
    gt = 1'b0;
    if (us_q) begin
      lt = $signed(s_data) < $signed(best_q);
      gt = $signed(s_data) > $signed(best_q);
    end else begin
      lt = s_data < best_q;
      gt = s_data > best_q;
    end
    better   = mm_q ? gt : lt;
`ifdef MINMAX_STREAM_LAST_EN
    end_beat = (cnt_q == LAST_IDX) || s_last;
`else
    end_beat = (cnt_q == LAST_IDX);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    idx_d   = idx_q;
    us_d    = us_q;
    mm_d    = mm_q;
`ifdef MINMAX_STREAM_LAST_EN
    count_d = count_q;
`endif
    case (state_q)
      IDLE, ACC: begin
        if (beat) begin
          if (state_q == IDLE) begin
            us_d   = us_sel;
            mm_d   = min_max_sel;
            best_d = s_data;
            idx_d  = '0;
          end else if (better) begin
            best_d = s_data;
            idx_d  = cnt_q;
          end
          if (end_beat) begin
            state_d = OUT;
            cnt_d   = '0;
`ifdef MINMAX_STREAM_LAST_EN
            count_d = {1'b0, cnt_q} + (IDXW + 1)'(1);
`endif
          end else begin
            state_d = ACC;
            cnt_d   = cnt_q + IDXW'(1);
          end
        end
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      us_q    <= 1'b0;
      mm_q    <= 1'b0;
      alive_q <= 1'b0;
`ifdef MINMAX_STREAM_LAST_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      us_q    <= us_d;
      mm_q    <= mm_d;
      alive_q <= 1'b1;
`ifdef MINMAX_STREAM_LAST_EN
      count_q <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_minmax_stream.sv
// Directed and randomised checks of minmax_stream (W=12, NI=9) against a small reference model.
module tb_minmax_stream;

  logic        clk;
  logic        rst_n;
  logic        us_sel;
  logic        min_max_sel;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_result;
  logic [3:0]  m_index;
`ifdef MINMAX_STREAM_LAST_EN
  logic        s_last;
  logic [4:0]  m_count;
  int          exp_cnt_g;
`endif

  int checks;
  int failures;

  minmax_stream #(.W(12), .NI(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .us_sel      (us_sel),
    .min_max_sel (min_max_sel),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
`ifdef MINMAX_STREAM_LAST_EN
    .s_last      (s_last),
    .m_count     (m_count),
`endif
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_result    (m_result),
    .m_index     (m_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_beat(input logic [11:0] d, input logic us, input logic mm);
    int n;
    s_valid     = 1'b1;
    s_data      = d;
    us_sel      = us;
    min_max_sel = mm;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_eq("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid     = 1'b0;
    s_data      = 12'(($urandom));
    us_sel      = 1'($urandom);
    min_max_sel = 1'($urandom);
  endtask

  task automatic get_result(input logic [11:0] er, input logic [3:0] ei, input int hold);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_eq("result_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_mvalid", 32'(m_valid), 32'd1);
      check_eq("hold_result", 32'(m_result), 32'(er));
      check_eq("hold_sready", 32'(s_ready), 32'd0);
    end
    check_eq("result", 32'(m_result), 32'(er));
    check_eq("index", 32'(m_index), 32'(ei));
`ifdef MINMAX_STREAM_LAST_EN
    check_eq("count", 32'(m_count), 32'(exp_cnt_g));
`endif
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check_eq("after_xfer_mvalid", 32'(m_valid), 32'd0);
    check_eq("after_xfer_sready", 32'(s_ready), 32'd1);
  endtask

  function automatic void ref_minmax(input logic [11:0] d[9], input logic us, input logic mm,
                                     output logic [11:0] r, output logic [3:0] ix);
    logic lt, gt;
    r  = d[0];
    ix = 4'd0;
    for (int k = 1; k < 9; k++) begin
      if (us) begin
        lt = $signed(d[k]) < $signed(r);
        gt = $signed(d[k]) > $signed(r);
      end else begin
        lt = d[k] < r;
        gt = d[k] > r;
      end
      if (mm ? gt : lt) begin
        r  = d[k];
        ix = 4'(k);
      end
    end
  endfunction

  task automatic send_frame(input logic [11:0] d[9], input logic us, input logic mm);
    for (int k = 0; k < 9; k++) send_beat(d[k], us, mm);
  endtask

  logic [11:0] vec[9];
  logic [11:0] pool[6];
  logic [11:0] er;
  logic [3:0]  ei;
  logic        rus, rmm;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    us_sel = 1'b0;
    min_max_sel = 1'b0;
    s_valid = 1'b0;
    s_data = 12'h000;
    m_ready = 1'b0;
`ifdef MINMAX_STREAM_LAST_EN
    s_last = 1'b0;
    exp_cnt_g = 9;
`endif
    idle_cycles(3);
    check_eq("rst_sready", 32'(s_ready), 32'd0);
    check_eq("rst_mvalid", 32'(m_valid), 32'd0);
    check_eq("rst_result", 32'(m_result), 32'd0);
    check_eq("rst_index", 32'(m_index), 32'd0);
`ifdef MINMAX_STREAM_LAST_EN
    check_eq("rst_count", 32'(m_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    check_eq("post_rst_sready", 32'(s_ready), 32'd1);

    // unsigned min with a tie; result held while consumer stalls
    vec = '{12'd5, 12'd3, 12'd9, 12'd3, 12'd7, 12'd100, 12'd4, 12'd8, 12'd6};
    send_frame(vec, 1'b0, 1'b0);
    check_eq("latency_mvalid", 32'(m_valid), 32'd1);
    get_result(12'd3, 4'd1, 5);

    // signed max, then same data unsigned min
    vec = '{12'h800, 12'hFFF, 12'h7FF, 12'h000, 12'h7FF, 12'h001, 12'h002, 12'h003, 12'h004};
    send_frame(vec, 1'b1, 1'b1);
    get_result(12'h7FF, 4'd2, 0);
    send_frame(vec, 1'b0, 1'b0);
    get_result(12'h000, 4'd3, 0);
    vec = '{12'h005, 12'h7FF, 12'h800, 12'hFFF, 12'h800, 12'h000, 12'h001, 12'h7FE, 12'h003};
    send_frame(vec, 1'b1, 1'b0);
    get_result(12'h800, 4'd2, 0);
    send_frame(vec, 1'b0, 1'b1);
    get_result(12'hFFF, 4'd3, 0);

    // mode bits toggled after beat 0 must be ignored
    vec = '{12'd100, 12'hF00, 12'd50, 12'd300, 12'd50, 12'd400, 12'd25, 12'd7, 12'd8};
    send_beat(vec[0], 1'b0, 1'b1);
    for (int k = 1; k < 9; k++) send_beat(vec[k], 1'(k), 1'(k + 1));
    get_result(12'hF00, 4'd1, 0);

    // reset mid-frame discards the partial frame
    for (int k = 0; k < 5; k++) send_beat(12'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_mvalid", 32'(m_valid), 32'd0);
    check_eq("midrst_sready", 32'(s_ready), 32'd0);
    idle_cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    check_eq("postrst_mvalid", 32'(m_valid), 32'd0);
    vec = '{12'd50, 12'd40, 12'd60, 12'd40, 12'd70, 12'd10, 12'd90, 12'd10, 12'd20};
    send_frame(vec, 1'b0, 1'b0);
    get_result(12'd10, 4'd5, 0);

    // early end of frame (or full 9 beats without the feature)
    send_beat(12'd10, 1'b0, 1'b1);
    send_beat(12'd20, 1'b0, 1'b1);
    send_beat(12'd5, 1'b0, 1'b1);
`ifdef MINMAX_STREAM_LAST_EN
    s_last = 1'b1;
    send_beat(12'd30, 1'b0, 1'b1);
    s_last = 1'b0;
    exp_cnt_g = 4;
    get_result(12'd30, 4'd3, 0);
    exp_cnt_g = 9;
`else
    send_beat(12'd30, 1'b0, 1'b1);
    check_eq("no_last_mvalid", 32'(m_valid), 32'd0);
    check_eq("no_last_sready", 32'(s_ready), 32'd1);
    for (int k = 4; k < 9; k++) send_beat(12'd0, 1'b0, 1'b1);
    get_result(12'd30, 4'd3, 0);
`endif

    // random frames with input gaps, stalls and ties
    pool = '{12'h000, 12'h7FF, 12'h800, 12'hFFF, 12'h001, 12'h002};
    for (int f = 0; f < 1000; f++) begin
      rus = 1'($urandom);
      rmm = 1'($urandom);
      for (int k = 0; k < 9; k++) begin
        if ($urandom_range(0, 1) == 0) vec[k] = 12'($urandom);
        else vec[k] = pool[$urandom_range(0, 5)];
      end
      ref_minmax(vec, rus, rmm, er, ei);
      for (int k = 0; k < 9; k++) begin
        idle_cycles($urandom_range(0, 2));
        if (k == 0) send_beat(vec[k], rus, rmm);
        else send_beat(vec[k], 1'($urandom), 1'($urandom));
      end
      get_result(er, ei, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
